// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard/flush controller.
// Register-file geometry, default write-back latency, canonical NOP.
package pipeline_hazard_ctrl_pkg;
  localparam int          REG_ADDR_W = 5;
  localparam int          NUM_REGS   = 32;
  localparam int          WB_LAT_DEF = 3;
  localparam logic [31:0] NOP_INST   = 32'h00000013;
endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: per-register pending-write down-counters.
// Ports: i_clk, i_rst_n (sync, low), i_set/i_set_addr (issue of a
// write), o_pend_mask (registered, bit r = x r still pending).
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  output logic [NUM_REGS-1:0]   o_pend_mask
);
  localparam int PW = $clog2(WB_LAT + 1);
  localparam logic [PW-1:0] LOAD = PW'(WB_LAT);

  logic [PW-1:0]       r_pend [NUM_REGS];
  logic [PW-1:0]       w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] r_mask;
  logic [NUM_REGS-1:0] w_mask_nxt;

  // x0 never tracks; a fresh issue wins over the decrement.
  always_comb begin
    w_mask_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_pend_nxt[r] = '0;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      if (i_set && i_set_addr == REG_ADDR_W'(r)) begin
        w_pend_nxt[r] = LOAD;
      end else if (r_pend[r] != '0) begin
        w_pend_nxt[r] = r_pend[r] - 1'b1;
      end
      w_mask_nxt[r] = (w_pend_nxt[r] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= '0;
      end
      r_mask <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_mask <= w_mask_nxt;
    end
  end

  assign o_pend_mask = r_mask;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/flush controller: RAW stall via scoreboard, flush on
// taken jump/branch, saturating stall/flush performance counters.
// Ports: clk, reset (sync, low); ID operand/dest info; ex_jump_flag;
// stall, id_ex_bubble, if_id_flush, pend_mask, stall_count, flush_count.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rf_wen,
  input  logic                  ex_jump_flag,
  output logic                  stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  logic [NUM_REGS-1:0] w_mask;
  logic                w_rs1_haz;
  logic                w_rs2_haz;
  logic                w_raw;
  logic                w_flush_sel;
  logic                w_stall_sel;
  logic                w_stall;
  logic                w_bubble;
  logic                w_flush;
  logic                w_issue;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  hazard_scoreboard #(
    .WB_LAT(WB_LAT)
  ) u_sb (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_set      (w_issue & id_rf_wen),
    .i_set_addr (id_rd_addr),
    .o_pend_mask(w_mask)
  );

  assign w_rs1_haz = id_rs1_used
                   & (id_rs1_addr != '0)
                   & w_mask[id_rs1_addr];
  assign w_rs2_haz = id_rs2_used
                   & (id_rs2_addr != '0)
                   & w_mask[id_rs2_addr];
  assign w_raw = id_valid & (w_rs1_haz | w_rs2_haz);

  // Selects made disjoint so flush outranks stall.
  assign w_flush_sel = reset & ex_jump_flag;
  assign w_stall_sel = reset & ~ex_jump_flag & w_raw;

  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    unique case (1'b1)
      w_flush_sel: begin
        w_flush  = 1'b1;
        w_bubble = 1'b1;
      end
      w_stall_sel: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_issue = id_valid & ~w_stall & ~ex_jump_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall        = w_stall;
  assign id_ex_bubble = w_bubble;
  assign if_id_flush  = w_flush;
  assign pend_mask    = w_mask;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a ready-time model.
// Two DUTs share stimulus: CNT_W=32 and CNT_W=4 (saturation).
module tb_pipeline_hazard_ctrl;
  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_rf_wen;
  logic        ex_jump_flag;
  logic        stall, bub, flush;
  logic [31:0] pmask;
  logic [31:0] scnt, fcnt;
  logic        stall4, bub4, flush4;
  logic [31:0] pmask4;
  logic [3:0]  scnt4, fcnt4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WB_LAT(WB_LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen),
    .ex_jump_flag(ex_jump_flag), .stall(stall),
    .id_ex_bubble(bub), .if_id_flush(flush),
    .pend_mask(pmask), .stall_count(scnt), .flush_count(fcnt)
  );

  pipeline_hazard_ctrl #(.WB_LAT(WB_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen),
    .ex_jump_flag(ex_jump_flag), .stall(stall4),
    .id_ex_bubble(bub4), .if_id_flush(flush4),
    .pend_mask(pmask4), .stall_count(scnt4), .flush_count(fcnt4)
  );

  int     n_chk = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     ready_at [32];
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // One ID cycle: drive, check against the model, advance the model.
  task automatic step(input bit v, input logic [4:0] a1, input bit u1,
                      input logic [4:0] a2, input bit u2,
                      input logic [4:0] rd, input bit we,
                      input bit j, input bit rs);
    bit          haz, e_stall, e_flush;
    logic [31:0] e_mask;
    id_valid = v; id_rs1_addr = a1; id_rs1_used = u1;
    id_rs2_addr = a2; id_rs2_used = u2;
    id_rd_addr = rd; id_rf_wen = we;
    ex_jump_flag = j; reset = rs;
    #2;
    haz = v && ((u1 && a1 != 0 && cyc < ready_at[a1]) ||
                (u2 && a2 != 0 && cyc < ready_at[a2]));
    e_flush = rs && j;
    e_stall = rs && !j && haz;
    e_mask = '0;
    for (int r = 1; r < 32; r++) e_mask[r] = (cyc < ready_at[r]);
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
    chk("bubble", {63'd0, bub}, {63'd0, e_stall | e_flush});
    chk("flush", {63'd0, flush}, {63'd0, e_flush});
    chk("pend_mask", {32'd0, pmask}, {32'd0, e_mask});
    chk("stall_count", {32'd0, scnt}, m_stall);
    chk("flush_count", {32'd0, fcnt}, m_flush);
    chk("stall_count4", {60'd0, scnt4}, sat15(m_stall));
    chk("flush_count4", {60'd0, fcnt4}, sat15(m_flush));
    @(posedge clk);
    if (!rs) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e_stall) m_stall++;
      if (e_flush) m_flush++;
      if (v && !e_stall && !j && we && rd != 0)
        ready_at[rd] = cyc + 1 + WB_LAT;
    end
    cyc++;
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    reset = 1'b0; id_valid = 1'b0; id_rs1_addr = '0; id_rs1_used = 1'b0;
    id_rs2_addr = '0; id_rs2_used = 1'b0; id_rd_addr = '0;
    id_rf_wen = 1'b0; ex_jump_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset-state check while still in reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // RAW on x5: three stall cycles, then issue
    step(1, 0, 0, 0, 0, 5, 1, 0, 1);
    repeat (4) step(1, 5, 1, 1, 1, 6, 1, 0, 1);
    chk("raw_stalls", {32'd0, scnt}, 64'd3);
    // x0 and unused sources never stall
    step(1, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1, 7, 1, 0, 1);
    step(1, 0, 0, 0, 0, 8, 1, 0, 1);
    step(1, 8, 0, 8, 0, 8, 1, 0, 1);
    // jump while ID has a hazard: flush wins, rd 12 not set
    step(1, 0, 0, 0, 0, 11, 1, 0, 1);
    step(1, 11, 1, 0, 0, 12, 1, 1, 1);
    step(1, 12, 1, 0, 0, 13, 0, 0, 1);
    // WAW on x9: reader released only three cycles after reload
    step(1, 0, 0, 0, 0, 9, 1, 0, 1);
    step(1, 0, 0, 0, 0, 9, 1, 0, 1);
    repeat (4) step(1, 9, 1, 0, 0, 14, 1, 0, 1);
    // reset in the middle of a stall
    step(1, 0, 0, 0, 0, 10, 1, 0, 1);
    step(1, 0, 0, 10, 1, 15, 1, 0, 1);
    step(1, 0, 0, 10, 1, 15, 1, 0, 1);
    step(1, 0, 0, 10, 1, 15, 1, 0, 0);
    step(1, 0, 0, 10, 1, 15, 1, 0, 1);
    // random traffic over a small register set
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8,
           5'($urandom_range(0, 4)), $urandom_range(0, 9) < 7,
           5'($urandom_range(0, 4)), $urandom_range(0, 9) < 7,
           5'($urandom_range(0, 4)), $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It holds a per-register scoreboard of in-flight writes and stalls an ID-stage instruction whose sources are still pending. It also flushes wrong-path instructions when EX resolves a taken jump or branch, and keeps stall and flush performance counters. It replaces the inline rd-match NOP-injection logic in the CPU top level.

Parameters:
WB_LAT, 3, cycles from ID issue until the register-file write is visible to a later ID read (ID→EX→MEM→WB)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
id_valid  in  1  ID holds a real instruction, not a NOP or bubble
id_rs1_addr  in  5  ID source 1 register
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_addr  in  5  ID source 2 register
id_rs2_used  in  1  ID instruction reads rs2
id_rd_addr  in  5  ID destination register
id_rf_wen  in  1  ID instruction writes rd
ex_jump_flag  in  1  EX resolved a taken jump or branch this cycle
stall  out  1  hold PC and IF/ID this cycle
id_ex_bubble  out  1  load a bubble into ID/EX (rf_wen=0, mem_wen=0, valid=0)
if_id_flush  out  1  load NOP 32'h00000013 into IF/ID
pend_mask  out  32  bit r = 1 while x r has a pending write
stall_count  out  CNT_W  cycles with stall=1
flush_count  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Scoreboard: 32 down-counters pend[r], each $clog2(WB_LAT+1) bits wide. pend[0] is always 0.
- pend_mask[r] = (pend[r] != 0). It is a registered output.
- raw_hazard (comb) = id_valid & ((id_rs1_used & rs1!=0 & pend[rs1]!=0) | (id_rs2_used & rs2!=0 & pend[rs2]!=0)).
- Flush has priority over stall:
  - ex_jump_flag=1 → if_id_flush=1, id_ex_bubble=1, stall=0. PC loads the jump target.
  - else raw_hazard=1 → stall=1, id_ex_bubble=1, if_id_flush=0.
  - else all three are 0.
- These three outputs are combinational from inputs and registered state (zero latency). They are forced to 0 while reset==0.
- issue = id_valid & !stall & !ex_jump_flag.
- Per clock edge, for each r≠0:
  - if issue & id_rf_wen & id_rd_addr==r, then pend[r] <= WB_LAT. Issue wins over a simultaneous decrement of the same r.
  - else if pend[r]!=0, then pend[r] <= pend[r]-1.
- A WAW re-issue to a pending rd reloads the counter to WB_LAT. No stall is taken for WAW.
- A write to rd=0 never sets the scoreboard.
- No scoreboard cancel on flush: the only wrong-path instruction, in ID, is blocked from issuing by the flush.
- Counters:
  - stall_count += 1 on each cycle with stall=1.
  - flush_count += 1 on each cycle with if_id_flush=1.
  - Both saturate at all-ones; no wrap.
- Reset (reset==0 at edge): pend[*]=0, pend_mask=0, stall_count=0, flush_count=0.
- Reset mid-stall: pending state is discarded and stall is 0 in the first cycle after reset deasserts.

Decomposition:
- Shared package holds: WB_LAT default, NOP_INST = 32'h00000013, REG_ADDR_W = 5, NUM_REGS = 32.
- One sub-module: hazard_scoreboard. It contains the pend[] counter array, set/decrement logic and pend_mask.
- Priority logic and counters stay in pipeline_hazard_ctrl.

Test Plan:
- RAW: addi x5 issues at cycle 0; add x6,x5,x1 enters ID at cycle 1 → stall=1 for cycles 1–3, issue at cycle 4, stall_count=3.
- rs=x0 and unused rs: add x7,x0,x0 after writes to x0; lui x8 (rs unused) after addi x8 → stall never asserted, pend_mask[0]=0.
- Taken jump, with ex_jump_flag=1 for one cycle while ID has a hazard → if_id_flush=1, id_ex_bubble=1, stall=0; flush_count=1; the hazard instruction does not set pend.
- WAW: addi x9 at cycle 0, addi x9 at cycle 1 → pend[9] reloads to 3 at cycle 2; a reader of x9 in ID is released only at cycle 5.
- Counter saturation: preload via CNT_W=4 build, hold a hazard for 20 cycles → stall_count sticks at 15.
- Reset: assert reset=0 at cycle 2 of a 3-cycle stall → next cycle pend_mask=0, stall=0, both counters=0.
